function_unit_driver: RTL

Sequential front-end that sits between the issue stage and the combinational function unit. It accepts operation commands over a valid/ready handshake and drives the function unit's A/B/FunctionSelect/SH inputs from registered operands. It captures Result and the V/C/N/Z flags and returns them over a valid/ready response channel. It also implements unsigned 32x32->64 multiply as a 32-cycle shift-add sequence, using the function unit's add operation.

---
 rtl/function_unit_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/function_unit_driver.sv
// Sequential front-end for the combinational function unit: registered operand
// drive, result/flag capture over a valid/ready response, and a 32-step shift-add MULU.
module function_unit_driver #(
   parameter int DATA_WIDTH    = 32,
   parameter int SHIFTER_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [4:0]               cmd_op,
   input  logic [DATA_WIDTH-1:0]    cmd_a,
   input  logic [DATA_WIDTH-1:0]    cmd_b,
   input  logic [SHIFTER_WIDTH-1:0] cmd_sh,
   output logic [DATA_WIDTH-1:0]    fu_a,
   output logic [DATA_WIDTH-1:0]    fu_b,
   output logic [3:0]               fu_fs,
   output logic [SHIFTER_WIDTH-1:0] fu_sh,
   input  logic [DATA_WIDTH-1:0]    fu_result,
   input  logic                     fu_overflow,
   input  logic                     fu_carry,
   input  logic                     fu_negative,
   input  logic                     fu_zero,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_result,
   output logic [DATA_WIDTH-1:0]    rsp_hi,
   output logic [3:0]               rsp_flags
);

   localparam logic [4:0] OP_MULU   = 5'b10000;
   localparam logic [3:0] FS_PASS_A = 4'b0000;
   localparam logic [3:0] FS_ADD    = 4'b0010;
   localparam logic [3:0] FS_UNDEF  = 4'b1111;
   localparam int         CNT_W     = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   lo;
   logic [CNT_W-1:0]        cnt;
   logic [DATA_WIDTH-1:0]   mul_hi;
   logic [DATA_WIDTH-1:0]   mul_lo;

   // Non-MULU codes with bit4 set select the function unit's undefined slot.
   function automatic logic [3:0] decode_fs(input logic [4:0] op);
      return op[4] ? FS_UNDEF : op[3:0];
   endfunction

   // Add the multiplicand only when the current multiplier bit is set.
   function automatic logic [3:0] step_fs(input logic bit0);
      return bit0 ? FS_ADD : FS_PASS_A;
   endfunction

   function automatic logic [3:0] mul_flags(input logic [DATA_WIDTH-1:0] hi,
                                            input logic [DATA_WIDTH-1:0] low);
      return {(hi != '0), 1'b0, hi[DATA_WIDTH-1], ({hi, low} == '0)};
   endfunction

   // The adder carry becomes the new MSB as the 64-bit accumulator shifts right.
   always_comb begin
      {mul_hi, mul_lo} = {fu_carry, fu_result, lo[DATA_WIDTH-1:1]};
   end

   assign cmd_ready = (state == IDLE);

   // fu_a doubles as the high accumulator and fu_b as the multiplicand during MUL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lo         <= '0;
         cnt        <= '0;
         fu_a       <= '0;
         fu_b       <= '0;
         fu_fs      <= FS_PASS_A;
         fu_sh      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_hi     <= '0;
         rsp_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_op == OP_MULU) begin
                     fu_a  <= '0;
                     fu_b  <= cmd_b;
                     fu_sh <= '0;
                     fu_fs <= step_fs(cmd_a[0]);
                     lo    <= cmd_a;
                     cnt   <= '0;
                     state <= MUL;
                  end else begin
                     fu_a  <= cmd_a;
                     fu_b  <= cmd_b;
                     fu_sh <= cmd_sh;
                     fu_fs <= decode_fs(cmd_op);
                     state <= EXEC;
                  end
               end
            end

            EXEC: begin
               rsp_result <= fu_result;
               rsp_hi     <= '0;
               rsp_flags  <= {fu_overflow, fu_carry, fu_negative, fu_zero};
               rsp_valid  <= 1'b1;
               fu_fs      <= FS_PASS_A;
               state      <= RESP;
            end

            MUL: begin
               fu_a <= mul_hi;
               lo   <= mul_lo;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  rsp_hi     <= mul_hi;
                  rsp_result <= mul_lo;
                  rsp_flags  <= mul_flags(mul_hi, mul_lo);
                  rsp_valid  <= 1'b1;
                  fu_fs      <= FS_PASS_A;
                  state      <= RESP;
               end else begin
                  fu_fs <= step_fs(mul_lo[0]);
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
